// File: rtl/count_stream_checker.sv
// Observes a free-running counter's count/overflow stream, predicts every next sample,
// and reports lock state, mismatch pulses and saturating error/wrap statistics.
module count_stream_checker #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned LOCK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_in,
  input  logic             upstream_rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             overflow_in,
  input  logic             clear,
  output logic             locked,
  output logic             mismatch,
  output logic             sticky_err,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [WIDTH-1:0] expected_out
);

  localparam int unsigned GOOD_W = 8;
  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [ERR_W-1:0]  STAT_MAX = '1;
  localparam logic [GOOD_W-1:0] LOCK_N   = GOOD_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   prev_count;
  logic               prev_en;
  logic [GOOD_W-1:0]  good_cnt;
  logic [GOOD_W-1:0]  good_cnt_next;

  logic [WIDTH-1:0]   exp_count;
  logic               exp_ovf;
  logic               good;

  logic               mismatch_next;
  logic               sticky_next;
  logic [ERR_W-1:0]   err_next;
  logic [ERR_W-1:0]   wrap_next;

  // Prediction of the current sample from the previous one
  assign exp_count = prev_en ? prev_count + WIDTH'(1) : prev_count;
  assign exp_ovf   = prev_en && (prev_count == CNT_MAX);
  assign good      = (count_in == exp_count) && (overflow_in == exp_ovf);

  // State register, history and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      good_cnt     <= '0;
      prev_count   <= '0;
      prev_en      <= 1'b0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      sticky_err   <= 1'b0;
      err_count    <= '0;
      wrap_count   <= '0;
      expected_out <= '0;
    end else begin
      state        <= state_next;
      good_cnt     <= good_cnt_next;
      prev_count   <= upstream_rst ? '0 : count_in;
      prev_en      <= upstream_rst ? 1'b0 : enable_in;
      locked       <= (state_next == TRACK);
      mismatch     <= mismatch_next;
      sticky_err   <= sticky_next;
      err_count    <= err_next;
      wrap_count   <= wrap_next;
      expected_out <= exp_count;
    end
  end

  // Next-state logic: clear beats upstream reset, which beats checking
  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    if (clear) begin
      state_next    = IDLE;
      good_cnt_next = '0;
    end else if (upstream_rst) begin
      state_next    = SYNC;
      good_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next    = SYNC;
          good_cnt_next = '0;
        end
        SYNC: begin
          if (!good) begin
            good_cnt_next = '0;
          end else if (good_cnt + GOOD_W'(1) >= LOCK_N) begin
            state_next    = TRACK;
            good_cnt_next = '0;
          end else begin
            good_cnt_next = good_cnt + GOOD_W'(1);
          end
        end
        TRACK: begin
          if (!good) begin
            state_next    = SYNC;
            good_cnt_next = '0;
          end
        end
        default: begin
          state_next    = IDLE;
          good_cnt_next = '0;
        end
      endcase
    end
  end

  // Output logic: errors and wraps are only scored while tracking
  always_comb begin
    mismatch_next = 1'b0;
    sticky_next   = sticky_err;
    err_next      = err_count;
    wrap_next     = wrap_count;
    if (clear) begin
      sticky_next = 1'b0;
      err_next    = '0;
      wrap_next   = '0;
    end else if (!upstream_rst && (state == TRACK)) begin
      if (!good) begin
        mismatch_next = 1'b1;
        sticky_next   = 1'b1;
        if (err_count != STAT_MAX) err_next = err_count + ERR_W'(1);
      end else if (exp_ovf) begin
        if (wrap_count != STAT_MAX) wrap_next = wrap_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_stream_checker.sv
// Scoreboard bench: a bench-side counter drives the checker, a stream-level reference
// model queues expected outputs, and a negedge monitor pops and compares them.
module tb_count_stream_checker;

  localparam int W    = 8;
  localparam int EW   = 2;
  localparam int LOCK = 4;
  localparam int CMOD = 256;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable_in = 1'b0;
  logic          upstream_rst = 1'b0;
  logic [W-1:0]  count_in = '0;
  logic          overflow_in = 1'b0;
  logic          clear = 1'b0;
  logic          locked;
  logic          mismatch;
  logic          sticky_err;
  logic [EW-1:0] err_count;
  logic [EW-1:0] wrap_count;
  logic [W-1:0]  expected_out;

  count_stream_checker #(.WIDTH(W), .ERR_W(EW), .LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .upstream_rst(upstream_rst),
    .count_in(count_in), .overflow_in(overflow_in), .clear(clear),
    .locked(locked), .mismatch(mismatch), .sticky_err(sticky_err),
    .err_count(err_count), .wrap_count(wrap_count), .expected_out(expected_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit mismatch;
    bit sticky;
    int err;
    int wrap;
    int exp;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  // Reference model: stream-level bookkeeping (0 = idle, 1 = syncing, 2 = tracking)
  int m_mode = 0, m_prev = 0, m_run = 0, m_err = 0, m_wrap = 0;
  bit m_pen = 0, m_sticky = 0;

  // Bench-side ideal counter: present count and overflow flag
  int cc = 0;
  bit co = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
  endtask

  task automatic model(input bit r, input bit clr, input bit en, input bit ur,
                       input int c, input bit o);
    exp_t e;
    int   x;
    bit   xo, ok;
    e = '{default: 0};
    if (r) begin
      m_mode = 0; m_prev = 0; m_pen = 0; m_run = 0;
      m_err = 0; m_wrap = 0; m_sticky = 0;
    end else begin
      x  = m_pen ? (m_prev + 1) % CMOD : m_prev;
      xo = m_pen && (m_prev == CMOD - 1);
      ok = (c == x) && (o == xo);
      e.exp = x;
      if (clr) begin
        m_mode = 0; m_run = 0; m_err = 0; m_wrap = 0; m_sticky = 0;
      end else if (ur) begin
        m_mode = 1; m_run = 0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_run = 0;
      end else if (m_mode == 1) begin
        m_run = ok ? m_run + 1 : 0;
        if (m_run >= LOCK) begin
          m_mode = 2; m_run = 0;
        end
      end else if (!ok) begin
        e.mismatch = 1; m_sticky = 1;
        m_err = (m_err < SMAX) ? m_err + 1 : SMAX;
        m_mode = 1; m_run = 0;
      end else if (xo) begin
        m_wrap = (m_wrap < SMAX) ? m_wrap + 1 : SMAX;
      end
      m_prev = ur ? 0 : c;
      m_pen  = ur ? 1'b0 : en;
    end
    e.locked = (m_mode == 2);
    e.sticky = m_sticky;
    e.err    = m_err;
    e.wrap   = m_wrap;
    q.push_back(e);
  endtask

  // Present one sample, let the DUT take it, then queue the expected response
  task automatic sample(input bit r, input bit clr, input bit en, input bit ur,
                        input int c, input bit o);
    @(negedge clk);
    rst = r; clear = clr; enable_in = en; upstream_rst = ur;
    count_in = W'(c); overflow_in = o;
    @(posedge clk);
    #1;
    model(r, clr, en, ur, c, o);
  endtask

  // Drive the counter's present output, then advance it as real hardware would
  task automatic tick(input bit en, input bit ur, input bit clr, input bit r);
    sample(r, clr, en, ur, cc, co);
    if (ur) begin
      cc = 0; co = 0;
    end else if (en) begin
      co = (cc == CMOD - 1);
      cc = (cc + 1) % CMOD;
    end else begin
      co = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick(1, 0, 0, 0);
  endtask

  // Monitor: outputs are stable at the negedge following each sampling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("locked",       32'(locked),       32'(e.locked));
        chk("mismatch",     32'(mismatch),     32'(e.mismatch));
        chk("sticky_err",   32'(sticky_err),   32'(e.sticky));
        chk("err_count",    32'(err_count),    32'(e.err));
        chk("wrap_count",   32'(wrap_count),   32'(e.wrap));
        chk("expected_out", 32'(expected_out), 32'(e.exp));
      end
    end
  end

  initial begin
    int p;
    bit en, ur, clr, r;
    // reset, then lock onto a clean counter
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    run(8);
    // several wraps, driving wrap_count into saturation
    run(CMOD * 4);
    // stall with the count held, then a skipped value
    repeat (3) tick(0, 0, 0, 0);
    run(5);
    cc = (cc + 1) % CMOD;
    run(7);
    // upstream reset is excused; the same drop without it is not
    tick(1, 1, 0, 0);
    run(6);
    cc = 0; co = 0;
    run(7);
    // spurious overflow on a mid-range count
    co = 1;
    run(7);
    // missing overflow on a wrap
    while (cc != CMOD - 1) tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    co = 0;
    run(7);
    // overflow held into the sample after a wrap
    while (cc != CMOD - 1) tick(1, 0, 0, 0);
    run(2);
    co = 1;
    run(7);
    // saturate err_count, then clear concurrent with another error
    repeat (5) begin
      cc = (cc + 7) % CMOD; co = 0;
      run(6);
    end
    cc = (cc + 7) % CMOD;
    tick(1, 0, 1, 0);
    run(6);
    // reset while tracking
    tick(1, 0, 0, 1);
    run(6);
    // randomized traffic with occasional faults and control events
    repeat (3000) begin
      en  = ($urandom_range(0, 3) != 0);
      p   = $urandom_range(0, 199);
      ur  = (p == 3);
      clr = (p == 4);
      r   = (p == 5);
      if (p < 3) cc = $urandom_range(0, CMOD - 1);
      else if (p == 6) co = ~co;
      tick(en, ur, clr, r);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
